instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Boot-time instruction loader directly upstream of the CPU core. Accepts a byte
//  stream (UART/debug bridge), assembles little-endian 32-bit instruction words and
//  drives the core's wr_instr_en_i/wr_instr_i write port, one word per pulse.
//  Holds the core in reset until the whole program image is written.
// PARAMETERS
//  MAX_WORDS  1024  max program length in words; larger header count -> error
//  CNT_W      16    width of header word count and internal word counter
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      synchronous, active-high reset
//  byte_valid_i   in   1      byte_i valid
//  byte_i         in   8      stream byte
//  byte_ready_o   out  1      loader can accept a byte (registered)
//  restart_i      in   1      abort/restart load, return to IDLE
//  wr_instr_en_o  out  1      one-cycle write strobe -> CPU wr_instr_en_i
//  wr_instr_o     out  32     assembled instruction -> CPU wr_instr_i
//  cpu_rst_o      out  1      reset to CPU rst_i; 1 until load completes
//  done_o         out  1      load complete
//  err_o          out  1      load failed (count too large / checksum)
//  word_cnt_o     out  CNT_W  words written so far
// BEHAVIOUR
//  - Reset: state IDLE, byte_ready_o=0, wr_instr_en_o=0, wr_instr_o=0, cpu_rst_o=1,
//    done_o=0, err_o=0, word_cnt_o=0, byte index=0; partial word discarded.
//  - byte_ready_o=1 from the cycle after rst_i deasserts, in IDLE/HDR1/DATA(/CHK);
//    0 in DONE and ERR. Byte accepted on posedge where byte_valid_i & byte_ready_o.
//  - States: IDLE(=HDR0) -> HDR1 -> DATA -> [CHK] -> DONE; any -> ERR on fault.
//  - IDLE: accepted byte = count[7:0]. HDR1: accepted byte = count[15:8].
//    count==0 -> DONE (CHK if enabled); count>MAX_WORDS -> ERR; else DATA.
//  - DATA: byte k (k=0..3) stored in word[8k+7:8k]. On acceptance of byte 3,
//    next cycle: wr_instr_en_o=1 exactly one cycle, wr_instr_o=word, word_cnt_o+1.
//    wr_instr_o holds its value after the strobe. Back-to-back bytes sustain one
//    word per 4 cycles; byte_valid_i gaps only stall, never drop.
//  - Last word: state -> DONE (or CHK); done_o=1 and cpu_rst_o=0 one cycle after
//    the final wr_instr_en_o pulse, so core leaves reset only after last write.
//  - ERR: err_o=1, cpu_rst_o stays 1, no further strobes; sticky until restart/rst.
//  - restart_i (any state): next cycle IDLE, counters/partial word cleared,
//    cpu_rst_o=1, done_o=0, err_o=0. Byte accepted same edge as restart_i is
//    dropped; restart_i wins. Strobe pending from that edge is suppressed.
//  - word_cnt_o is CNT_W bits; never wraps since count<=MAX_WORDS<2^CNT_W.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after last data byte (or header if count==0) state
//    CHK accepts one byte; compare to XOR of all data bytes (header excluded).
//    Match -> DONE (done_o/cpu_rst_o=0 next cycle); mismatch -> ERR.
//  Undefined: no CHK state; DATA/HDR1 go straight to DONE; err_o only from
//    count>MAX_WORDS.
// TESTING
//  1 rst, send 01 00 13 00 00 00 -> one strobe wr_instr_o=0x00000013 cycle after
//    last byte; next cycle done_o=1, cpu_rst_o=0, word_cnt_o=1.
//  2 send 02 00 93 00 50 00 13 81 10 00 with random valid gaps -> strobes
//    0x00500093 then 0x00108113, in order, no drops, exactly 2 pulses.
//  3 send 00 00 (no checksum build) -> no strobes; done_o=1 after header.
//  4 send 01 04 (1025 > MAX_WORDS) -> err_o=1, byte_ready_o=0, cpu_rst_o=1, no strobe.
//  5 count=1, 2 data bytes, then rst_i -> no strobe, IDLE; full reload then works.
//  6 LOADER_CHECKSUM_EN: 01 00 13 00 00 00 13 -> done_o=1; trailing 12 instead
//    -> err_o=1, cpu_rst_o=1; restart_i then clears err_o, byte_ready_o=1.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: byte-stream boot loader assembling little-endian words into the CPU write port.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  output logic             byte_ready_o,
  input  logic             restart_i,
  output logic             wr_instr_en_o,
  output logic [31:0]      wr_instr_o,
  output logic             cpu_rst_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR1, DATA, DONE, ERR, CHK} state_t;
  localparam state_t FIN = CHK;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic [2:0] {IDLE, HDR1, DATA, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif
  state_t           state_q, state_d;
  logic [7:0]       lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d, hdr;
  logic [23:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      instr_q, instr_d;
  logic             wr_en_q, wr_en_d, ready_q, ready_d, done_q, done_d, acc;
  assign acc = byte_valid_i & ready_q;
  assign hdr = CNT_W'({byte_i, lo_q});
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    wr_en_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: if (acc) begin
        lo_d    = byte_i;
        state_d = HDR1;
      end
      HDR1: if (acc) begin
        cnt_d   = hdr;
        state_d = hdr == '0 ? FIN : hdr > CNT_W'(MAX_WORDS) ? ERR : DATA;
      end
      DATA: if (acc) begin
        // bytes shift in from the top so byte 0 ends up in bits [7:0]
        word_d = {byte_i, word_q[23:8]};
        idx_d  = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q ^ byte_i;
`endif
        if (idx_q == 2'd3) begin
          wr_en_d = 1'b1;
          instr_d = {byte_i, word_q};
          wcnt_d  = wcnt_q + CNT_W'(1);
          state_d = wcnt_q + CNT_W'(1) == cnt_q ? FIN : DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: if (acc) state_d = byte_i == csum_q ? DONE : ERR;
`endif
      default: ;
    endcase
    if (restart_i) begin
      state_d = IDLE;
      wcnt_d  = '0;
      word_d  = '0;
      idx_d   = '0;
      wr_en_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end
    ready_d = state_d != DONE && state_d != ERR;
    // done trails entry into DONE so the core leaves reset after the last strobe
    done_d  = state_q == DONE && !restart_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lo_q    <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      instr_q <= '0;
      wr_en_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      wr_en_q <= wr_en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  assign byte_ready_o  = ready_q;
  assign wr_instr_en_o = wr_en_q;
  assign wr_instr_o    = instr_q;
  assign cpu_rst_o     = ~done_q;
  assign done_o        = done_q;
  assign err_o         = state_q == ERR;
  assign word_cnt_o    = wcnt_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed load sequences with a scoreboard of expected instruction words.
module tb_instr_loader;
  logic        clk = 1'b0, rst_i = 1'b1, byte_valid_i = 1'b0, restart_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_ready_o, wr_instr_en_o, cpu_rst_o, done_o, err_o;
  logic [31:0] wr_instr_o;
  logic [15:0] word_cnt_o;
  logic [31:0] exp_q[$];
  logic [7:0]  csum;
  int n_assert = 0, n_fail = 0, n_strobe = 0, s0;

  instr_loader dut (
    .clk_i(clk), .rst_i(rst_i), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
    .byte_ready_o(byte_ready_o), .restart_i(restart_i), .wr_instr_en_o(wr_instr_en_o),
    .wr_instr_o(wr_instr_o), .cpu_rst_o(cpu_rst_o), .done_o(done_o), .err_o(err_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (wr_instr_en_o) begin
    n_strobe++;
    check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check("wr_instr", wr_instr_o, exp_q.pop_front());
  end

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic load(input logic [31:0] ws[$], input int gmax);
    csum = 8'h00;
    send(8'(ws.size()), $urandom_range(0, gmax));
    send(8'(ws.size() >> 8), $urandom_range(0, gmax));
    foreach (ws[i]) begin
      exp_q.push_back(ws[i]);
      for (int k = 0; k < 4; k++) begin
        csum ^= ws[i][8*k +: 8];
        send(ws[i][8*k +: 8], $urandom_range(0, gmax));
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send(csum, 0);
`endif
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(byte_ready_o), 32'd0);
    check("rst_wr_en", 32'(wr_instr_en_o), 32'd0);
    check("rst_instr", wr_instr_o, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_wcnt", 32'(word_cnt_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(byte_ready_o), 32'd1);
    // single word, back-to-back bytes
    s0 = n_strobe;
    load('{32'h00000013}, 0);
    check("t1_strobe_now", 32'(wr_instr_en_o), 32'd1);
    check("t1_done_not_yet", 32'(done_o), 32'd0);
    check("t1_ready_low", 32'(byte_ready_o), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check("t1_wcnt", 32'(word_cnt_o), 32'd1);
    check("t1_single_pulse", 32'(wr_instr_en_o), 32'd0);
    check("t1_instr_held", wr_instr_o, 32'h00000013);
    check("t1_strobes", 32'(n_strobe - s0), 32'd1);
    // two words with random valid gaps
    do_reset();
    s0 = n_strobe;
    load('{32'h00500093, 32'h00108113}, 3);
    repeat (3) @(negedge clk);
    check("t2_strobes", 32'(n_strobe - s0), 32'd2);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t2_done", 32'(done_o), 32'd1);
    check("t2_wcnt", 32'(word_cnt_o), 32'd2);
    // zero-length image
    do_reset();
    s0 = n_strobe;
    load('{}, 0);
    @(negedge clk);
    check("t3_done", 32'(done_o), 32'd1);
    check("t3_cpu_rst", 32'(cpu_rst_o), 32'd0);
    check("t3_strobes", 32'(n_strobe - s0), 32'd0);
    // count 1025 exceeds MAX_WORDS
    do_reset();
    s0 = n_strobe;
    send(8'h01, 0);
    send(8'h04, 0);
    @(negedge clk);
    check("t4_err", 32'(err_o), 32'd1);
    check("t4_ready", 32'(byte_ready_o), 32'd0);
    check("t4_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("t4_done", 32'(done_o), 32'd0);
    check("t4_strobes", 32'(n_strobe - s0), 32'd0);
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    check("t4_restart_err", 32'(err_o), 32'd0);
    check("t4_restart_ready", 32'(byte_ready_o), 32'd1);
    // partial word then reset, then full reload
    s0 = n_strobe;
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    do_reset();
    @(negedge clk);
    check("t5_strobes", 32'(n_strobe - s0), 32'd0);
    check("t5_wcnt", 32'(word_cnt_o), 32'd0);
    load('{32'hdeadbeef}, 1);
    @(negedge clk);
    check("t5_done", 32'(done_o), 32'd1);
    check("t5_wcnt_after", 32'(word_cnt_o), 32'd1);
    check("t5_strobes_after", 32'(n_strobe - s0), 32'd1);
    // restart coinciding with the final byte drops the byte and the strobe
    do_reset();
    s0 = n_strobe;
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    byte_i = 8'h44;
    byte_valid_i = 1'b1;
    restart_i = 1'b1;
    @(negedge clk);
    byte_valid_i = 1'b0;
    restart_i = 1'b0;
    @(negedge clk);
    check("t7_strobes", 32'(n_strobe - s0), 32'd0);
    check("t7_wcnt", 32'(word_cnt_o), 32'd0);
    check("t7_ready", 32'(byte_ready_o), 32'd1);
    check("t7_cpu_rst", 32'(cpu_rst_o), 32'd1);
    load('{32'h12345678}, 0);
    @(negedge clk);
    check("t7_reload_done", 32'(done_o), 32'd1);
    check("t7_reload_strobes", 32'(n_strobe - s0), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    exp_q.push_back(32'h00000013);
    foreach (exp_q[i]) ;
    send(8'h01, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h12, 0);
    @(negedge clk);
    check("t6_err", 32'(err_o), 32'd1);
    check("t6_cpu_rst", 32'(cpu_rst_o), 32'd1);
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    check("t6_restart_err", 32'(err_o), 32'd0);
    check("t6_restart_ready", 32'(byte_ready_o), 32'd1);
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
